// File: rtl/ama_riscv_hazard_control_pkg.sv
// Shared types and constants for the hazard sequencer: FSM state encoding,
// the x0 register address and the internal down-counter width.
package ama_riscv_hazard_control_pkg;

    typedef enum logic [1:0] {
        HZ_ST_RST_FLUSH  = 2'd0,
        HZ_ST_RUN        = 2'd1,
        HZ_ST_LOAD_STALL = 2'd2,
        HZ_ST_CTRL_WAIT  = 2'd3
    } hz_state_e;

    localparam logic [4:0] RF_X0_ZERO = 5'd0;

    // One shared down-counter serves both the post-reset flush and the load stall.
    localparam int HZ_CNT_W = 4;

endpackage

// File: rtl/ama_riscv_hazard_control_if.sv
// ID/EX hazard inputs and pipeline-control outputs of the hazard sequencer.
// The master is the core datapath and the slave is the hazard block.
interface ama_riscv_hazard_control_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             rs1_used_id;
    logic             rs2_used_id;
    logic             branch_inst_id;
    logic             jump_inst_id;
    logic             load_inst_ex;
    logic             reg_we_ex;
    logic [4:0]       rd_ex;
    logic             cnt_clr;
    logic             stall_if;
    logic             stall_id;
    logic             flush_id;
    logic             bubble_ex;
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id, branch_inst_id,
               jump_inst_id, load_inst_ex, reg_we_ex, rd_ex, cnt_clr,
        input  stall_if, stall_id, flush_id, bubble_ex, hz_state, stall_cnt
    );

    modport slave (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, branch_inst_id,
               jump_inst_id, load_inst_ex, reg_we_ex, rd_ex, cnt_clr,
        output stall_if, stall_id, flush_id, bubble_ex, hz_state, stall_cnt
    );
endinterface

// File: rtl/ama_riscv_sat_counter.sv
// Saturating up-counter with synchronous clear, for performance counters.
module ama_riscv_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ama_riscv_hazard_control.sv
// Stall/flush sequencer for the 3-stage core: load-use stalls, one-bubble
// control-transfer handling and a forced flush window after reset.
module ama_riscv_hazard_control
    import ama_riscv_hazard_control_pkg::*;
#(
    parameter int RST_FLUSH_CYC = 2,
    parameter int LOAD_LAT      = 1,
    parameter int CNT_W         = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    ama_riscv_hazard_control_if.slave     hz
);

    hz_state_e           state_q, state_d;
    logic [HZ_CNT_W-1:0] dcnt_q, dcnt_d;
    logic                load_use;
    logic                ctrl;
    logic                stall_if, stall_id, flush_id, bubble_ex;

    assign load_use = hz.load_inst_ex && hz.reg_we_ex && (hz.rd_ex != RF_X0_ZERO) &&
                      ((hz.rs1_used_id && (hz.rs1_id == hz.rd_ex)) ||
                       (hz.rs2_used_id && (hz.rs2_id == hz.rd_ex)));
    assign ctrl = hz.branch_inst_id || hz.jump_inst_id;

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        case (state_q)
            HZ_ST_RST_FLUSH: begin
                stall_if = 1'b1;
                flush_id = 1'b1;
                dcnt_d   = dcnt_q - 1'b1;
                if (dcnt_q == HZ_CNT_W'(1))
                    state_d = HZ_ST_RUN;
            end
            HZ_ST_RUN: begin
                // load_use wins: a dependent branch is re-seen here once the stall clears
                if (load_use) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = HZ_ST_LOAD_STALL;
                        dcnt_d  = HZ_CNT_W'(LOAD_LAT - 1);
                    end
                end else if (ctrl) begin
                    stall_if = 1'b1;
                    state_d  = HZ_ST_CTRL_WAIT;
                end
            end
            HZ_ST_LOAD_STALL: begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
                dcnt_d    = dcnt_q - 1'b1;
                if (dcnt_q == HZ_CNT_W'(1))
                    state_d = HZ_ST_RUN;
            end
            HZ_ST_CTRL_WAIT: begin
                flush_id = 1'b1;
                state_d  = HZ_ST_RUN;
            end
            default: state_d = HZ_ST_RST_FLUSH;
        endcase
        if (rst) begin
            stall_if  = 1'b1;
            flush_id  = 1'b1;
            stall_id  = 1'b0;
            bubble_ex = 1'b0;
            state_d   = HZ_ST_RST_FLUSH;
            dcnt_d    = HZ_CNT_W'(RST_FLUSH_CYC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HZ_ST_RST_FLUSH;
            dcnt_q  <= HZ_CNT_W'(RST_FLUSH_CYC);
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    ama_riscv_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (hz.cnt_clr),
        .inc (stall_if || stall_id),
        .cnt (hz.stall_cnt)
    );

    assign hz.stall_if  = stall_if;
    assign hz.stall_id  = stall_id;
    assign hz.flush_id  = flush_id;
    assign hz.bubble_ex = bubble_ex;
    assign hz.hz_state  = rst ? HZ_ST_RST_FLUSH : state_q;

endmodule

// File: tb/tb_ama_riscv_hazard_control.sv
// Scoreboard bench: two instances (default params, and LOAD_LAT=3/CNT_W=4)
// share one stimulus stream and are checked against a cycle-level reference model.
module tb_ama_riscv_hazard_control;

    localparam int A_L = 1, A_F = 2;
    localparam int B_L = 3, B_F = 2;
    localparam longint A_MAX = 64'hFFFF_FFFF;
    localparam longint B_MAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ama_riscv_hazard_control_if #(.CNT_W(32)) ifa ();
    ama_riscv_hazard_control_if #(.CNT_W(4))  ifb ();

    ama_riscv_hazard_control #(.RST_FLUSH_CYC(A_F), .LOAD_LAT(A_L), .CNT_W(32))
        dut_a (.clk(clk), .rst(rst), .hz(ifa));
    ama_riscv_hazard_control #(.RST_FLUSH_CYC(B_F), .LOAD_LAT(B_L), .CNT_W(4))
        dut_b (.clk(clk), .rst(rst), .hz(ifb));

    typedef struct {
        bit       rst;
        bit [4:0] rs1, rs2, rd;
        bit       u1, u2, br, jp, ld, we, clr;
    } stim_t;

    typedef struct {
        bit       sif, sid, fid, bub;
        int       hz;
        longint   cnt;
    } exp_t;

    // Remaining-work view of the pipeline rather than a state encoding.
    typedef struct {
        int     rst_left;
        int     stall_left;
        bit     ctrl_pend;
        longint cnt;
    } mst_t;

    typedef struct {
        exp_t a;
        exp_t b;
    } pair_t;

    pair_t q[$];
    mst_t  ma, mb;
    int    checks = 0;
    int    errors = 0;
    bit    stim_done = 1'b0;

    function automatic void model(input mst_t s, input stim_t i, input int lat, input int fl,
                                  input longint mx, output exp_t e, output mst_t n);
        bit lu;
        lu = i.ld && i.we && (i.rd != 0) &&
             ((i.u1 && i.rs1 == i.rd) || (i.u2 && i.rs2 == i.rd));
        e.sif = 0; e.sid = 0; e.fid = 0; e.bub = 0; e.hz = 1; e.cnt = s.cnt;
        n = s;
        if (i.rst) begin
            e.sif = 1; e.fid = 1; e.hz = 0;
            n.rst_left = fl; n.stall_left = 0; n.ctrl_pend = 0;
        end else if (s.rst_left > 0) begin
            e.sif = 1; e.fid = 1; e.hz = 0;
            n.rst_left = s.rst_left - 1;
        end else if (s.stall_left > 0) begin
            e.sif = 1; e.sid = 1; e.bub = 1; e.hz = 2;
            n.stall_left = s.stall_left - 1;
        end else if (s.ctrl_pend) begin
            e.fid = 1; e.hz = 3;
            n.ctrl_pend = 0;
        end else if (lu) begin
            e.sif = 1; e.sid = 1; e.bub = 1;
            n.stall_left = lat - 1;
        end else if (i.br || i.jp) begin
            e.sif = 1;
            n.ctrl_pend = 1;
        end
        if (i.rst || i.clr)
            n.cnt = 0;
        else if ((e.sif || e.sid) && s.cnt < mx)
            n.cnt = s.cnt + 1;
    endfunction

    task automatic drive(input stim_t s);
        rst = s.rst;
        ifa.rs1_id = s.rs1; ifa.rs2_id = s.rs2; ifa.rd_ex = s.rd;
        ifa.rs1_used_id = s.u1; ifa.rs2_used_id = s.u2;
        ifa.branch_inst_id = s.br; ifa.jump_inst_id = s.jp;
        ifa.load_inst_ex = s.ld; ifa.reg_we_ex = s.we; ifa.cnt_clr = s.clr;
        ifb.rs1_id = s.rs1; ifb.rs2_id = s.rs2; ifb.rd_ex = s.rd;
        ifb.rs1_used_id = s.u1; ifb.rs2_used_id = s.u2;
        ifb.branch_inst_id = s.br; ifb.jump_inst_id = s.jp;
        ifb.load_inst_ex = s.ld; ifb.reg_we_ex = s.we; ifb.cnt_clr = s.clr;
    endtask

    task automatic cycle(input stim_t s);
        pair_t p;
        mst_t  na, nb;
        drive(s);
        model(ma, s, A_L, A_F, A_MAX, p.a, na);
        model(mb, s, B_L, B_F, B_MAX, p.b, nb);
        q.push_back(p);
        @(posedge clk);
        ma = na; mb = nb;
        #1;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0;
        s.u1 = 0; s.u2 = 0; s.br = 0; s.jp = 0; s.ld = 0; s.we = 0; s.clr = 0;
        return s;
    endfunction

    function automatic stim_t ld_use(input bit [4:0] rd, input bit [4:0] r1, input bit [4:0] r2,
                                     input bit u1, input bit u2);
        stim_t s;
        s = idle();
        s.ld = 1; s.we = 1; s.rd = rd; s.rs1 = r1; s.rs2 = r2; s.u1 = u1; s.u2 = u2;
        return s;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            pair_t p;
            p = q.pop_front();
            chk("a.stall_if",  longint'(ifa.stall_if),  longint'(p.a.sif));
            chk("a.stall_id",  longint'(ifa.stall_id),  longint'(p.a.sid));
            chk("a.flush_id",  longint'(ifa.flush_id),  longint'(p.a.fid));
            chk("a.bubble_ex", longint'(ifa.bubble_ex), longint'(p.a.bub));
            chk("a.hz_state",  longint'(ifa.hz_state),  longint'(p.a.hz));
            chk("a.stall_cnt", longint'(ifa.stall_cnt), p.a.cnt);
            chk("b.stall_if",  longint'(ifb.stall_if),  longint'(p.b.sif));
            chk("b.stall_id",  longint'(ifb.stall_id),  longint'(p.b.sid));
            chk("b.flush_id",  longint'(ifb.flush_id),  longint'(p.b.fid));
            chk("b.bubble_ex", longint'(ifb.bubble_ex), longint'(p.b.bub));
            chk("b.hz_state",  longint'(ifb.hz_state),  longint'(p.b.hz));
            chk("b.stall_cnt", longint'(ifb.stall_cnt), p.b.cnt);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        drive(idle());
        rst = 1'b1;
        ma.rst_left = A_F; ma.stall_left = 0; ma.ctrl_pend = 0; ma.cnt = 0;
        mb.rst_left = B_F; mb.stall_left = 0; mb.ctrl_pend = 0; mb.cnt = 0;
        @(posedge clk); #1;

        // reset held, then release into the flush window
        s = idle(); s.rst = 1;
        repeat (3) cycle(s);
        repeat (4) cycle(idle());

        // rs1 load-use, then the same with rd=x0
        cycle(ld_use(5'd5, 5'd5, 5'd0, 1, 0));
        repeat (4) cycle(idle());
        cycle(ld_use(5'd0, 5'd0, 5'd0, 1, 1));
        cycle(idle());

        // rs2 load-use for the multi-cycle instance
        cycle(ld_use(5'd7, 5'd1, 5'd7, 0, 1));
        repeat (4) cycle(idle());

        // branch dependent on a load, then the branch alone
        s = ld_use(5'd3, 5'd3, 5'd0, 1, 0); s.br = 1;
        cycle(s);
        s = idle(); s.br = 1;
        repeat (3) cycle(s);
        repeat (3) cycle(idle());

        // single jump
        s = idle(); s.jp = 1;
        cycle(s);
        repeat (3) cycle(idle());

        // continuous load-use to saturate the 4-bit counter, clear mid-stall
        repeat (20) cycle(ld_use(5'd9, 5'd9, 5'd9, 1, 1));
        s = ld_use(5'd9, 5'd9, 5'd9, 1, 1); s.clr = 1;
        cycle(s);
        repeat (3) cycle(ld_use(5'd9, 5'd9, 5'd9, 1, 1));

        // reset in the middle of a multi-cycle load stall
        cycle(ld_use(5'd4, 5'd4, 5'd0, 1, 0));
        s = idle(); s.rst = 1;
        cycle(s);
        repeat (4) cycle(idle());

        for (int n = 0; n < 2500; n++) begin
            s.rst = ($urandom_range(0, 199) == 0);
            s.clr = ($urandom_range(0, 39) == 0);
            s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.rd  = 5'($urandom_range(0, 3));
            s.u1  = 1'($urandom_range(0, 1));
            s.u2  = 1'($urandom_range(0, 1));
            s.ld  = 1'($urandom_range(0, 1));
            s.we  = ($urandom_range(0, 3) != 0);
            s.br  = ($urandom_range(0, 6) == 0);
            s.jp  = ($urandom_range(0, 9) == 0);
            cycle(s);
        end
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", longint'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
